// File: rtl/pc_gen_ras.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_ras
// Brief    : Fetch PC generator with prioritised redirects (trap > branch >
//            return), a pending-redirect hold while stalled, a circular
//            return-address stack and a valid/ready fetch request.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen_ras #(
  parameter int unsigned       XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_ADDR = 32'h0000_1000,
  parameter logic [XLEN-1:0]   ADDR_MIN   = 32'h0000_1000,
  parameter logic [XLEN-1:0]   ADDR_MAX   = 32'h0000_2000,
  parameter logic [XLEN-1:0]   TRAP_VEC   = 32'h0000_1F00,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         trap_req,
  input  logic                         branch_taken,
  input  logic [XLEN-3:0]              branch_target,
  input  logic                         ras_push,
  input  logic [XLEN-3:0]              ret_addr,
  input  logic                         ras_pop,
  output logic                         pc_valid,
  input  logic                         pc_ready,
  output logic [XLEN-1:0]              pc_out,
  output logic                         range_fault,
  output logic                         ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // Fetch FSM encoding
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Redirect priorities; a larger value wins
  localparam logic [1:0] PRIO_RET  = 2'd0;
  localparam logic [1:0] PRIO_BR   = 2'd1;
  localparam logic [1:0] PRIO_TRAP = 2'd2;

  // Registered state
  logic [1:0]       state_q,     state_d;
  logic [XLEN-1:0]  pc_q,        pc_d;
  logic [XLEN-1:0]  pend_tgt_q,  pend_tgt_d;
  logic [1:0]       pend_prio_q, pend_prio_d;
  logic [PTR_W-1:0] top_q,       top_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             fault_q,     fault_d;
  logic             uflow_q,     uflow_d;
  logic [XLEN-3:0]  ras_mem_q [RAS_DEPTH];

  // Combinational helpers
  logic             w_active;
  logic             w_ras_empty;
  logic [XLEN-1:0]  w_ras_top;
  logic             w_pop_ok;
  logic             w_new_vld;
  logic [1:0]       w_new_prio;
  logic [XLEN-1:0]  w_new_tgt;
  logic [XLEN-1:0]  w_mrg_tgt;
  logic             w_cand_vld;
  logic [XLEN-1:0]  w_cand;
  logic             w_in_range;
  logic             w_ras_we;
  logic [PTR_W-1:0] w_ras_waddr;

  // Outputs come straight from registers: no path from pc_ready to pc_out
  assign pc_valid      = (state_q == ST_RUN);
  assign pc_out        = pc_q;
  assign range_fault   = fault_q;
  assign ras_underflow = uflow_q;
  assign ras_count     = cnt_q;

  // Select this cycle's highest-priority redirect request
  always_comb begin
    w_active    = (state_q != ST_BOOT);
    w_ras_empty = (cnt_q == '0);
    w_ras_top   = {ras_mem_q[top_q], 2'b00};
    // A pop is honoured (as a stack operation) whenever no trap is present;
    // it only redirects when nothing of higher priority is also requesting.
    w_pop_ok    = w_active && ras_pop && !trap_req && !w_ras_empty;
    w_new_vld   = w_active && (trap_req || branch_taken || w_pop_ok);
    w_new_prio  = PRIO_RET;
    w_new_tgt   = w_ras_top;
    if (trap_req) begin
      w_new_prio = PRIO_TRAP;
      w_new_tgt  = TRAP_VEC;
    end else if (branch_taken) begin
      w_new_prio = PRIO_BR;
      w_new_tgt  = {branch_target, 2'b00};
    end
  end

  // Fetch FSM, pending-redirect bookkeeping and next-PC candidate
  always_comb begin
    state_d     = state_q;
    pend_tgt_d  = pend_tgt_q;
    pend_prio_d = pend_prio_q;
    w_cand_vld  = 1'b0;
    w_cand      = pc_q;
    w_mrg_tgt   = pend_tgt_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          if (w_new_vld) begin
            state_d     = ST_HOLD;
            pend_tgt_d  = w_new_tgt;
            pend_prio_d = w_new_prio;
          end
        end else if (w_new_vld) begin
          // Redirects do not wait for the memory to accept the current PC
          w_cand_vld = 1'b1;
          w_cand     = w_new_tgt;
        end else if (pc_ready) begin
          w_cand_vld = 1'b1;
          w_cand     = pc_q + XLEN'(4);
        end
      end
      ST_HOLD: begin
        // A newer request replaces the pending one only at equal or higher priority
        if (w_new_vld && (w_new_prio >= pend_prio_q)) begin
          w_mrg_tgt   = w_new_tgt;
          pend_prio_d = w_new_prio;
        end
        if (stall) begin
          pend_tgt_d = w_mrg_tgt;
        end else begin
          state_d    = ST_RUN;
          w_cand_vld = 1'b1;
          w_cand     = w_mrg_tgt;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    w_in_range = (w_cand >= ADDR_MIN) && (w_cand < ADDR_MAX);
    fault_d    = w_cand_vld && !w_in_range;
    pc_d       = pc_q;
    if (w_cand_vld) begin
      pc_d = w_in_range ? w_cand : TRAP_VEC;
    end
  end

  // Return-address-stack pointer/count update and underflow detection
  always_comb begin
    top_d       = top_q;
    cnt_d       = cnt_q;
    uflow_d     = 1'b0;
    w_ras_we    = 1'b0;
    w_ras_waddr = top_q + PTR_W'(1);
    if (w_active && !trap_req) begin
      if (ras_pop && w_ras_empty) begin
        uflow_d = 1'b1;
      end
      if (ras_push && w_pop_ok) begin
        // Call and return together: the returned-to entry is replaced in place
        w_ras_we    = 1'b1;
        w_ras_waddr = top_q;
      end else if (ras_push) begin
        // Circular write; when full this lands on the oldest entry
        w_ras_we = 1'b1;
        top_d    = top_q + PTR_W'(1);
        if (cnt_q != CNT_FULL) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (w_pop_ok) begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    // Traps and rejected PCs invalidate all return predictions
    if ((w_active && trap_req) || fault_d) begin
      cnt_d = '0;
    end
  end

  // Control and PC state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_ADDR;
      pend_tgt_q  <= '0;
      pend_prio_q <= PRIO_RET;
      top_q       <= '1;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      uflow_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_prio_q <= pend_prio_d;
      top_q       <= top_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      uflow_q     <= uflow_d;
    end
  end

  // Stack storage; contents are qualified by cnt_q so no reset is needed
  always_ff @(posedge clk) begin
    if (w_ras_we) begin
      ras_mem_q[w_ras_waddr] <= ret_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen_ras
// Brief    : Directed self-checking bench for pc_gen_ras using an
//            expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen_ras;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        trap_req;
  logic        branch_taken;
  logic [29:0] branch_target;
  logic        ras_push;
  logic [29:0] ret_addr;
  logic        ras_pop;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc_out;
  logic        range_fault;
  logic        ras_underflow;
  logic [2:0]  ras_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        vld;
    logic        rf;
    logic        uf;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb_q[$];

  pc_gen_ras dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .trap_req      (trap_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ras_push      (ras_push),
    .ret_addr      (ret_addr),
    .ras_pop       (ras_pop),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .pc_out        (pc_out),
    .range_fault   (range_fault),
    .ras_underflow (ras_underflow),
    .ras_count     (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [29:0] wa(input logic [31:0] a);
    return a[31:2];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic vld,
                            input logic rf, input logic uf, input logic [2:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.vld = vld; e.rf = rf; e.uf = uf; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, ".pc"},  pc_out,                e.pc);
    chk({e.tag, ".vld"}, {31'd0, pc_valid},      {31'd0, e.vld});
    chk({e.tag, ".rf"},  {31'd0, range_fault},   {31'd0, e.rf});
    chk({e.tag, ".uf"},  {31'd0, ras_underflow}, {31'd0, e.uf});
    chk({e.tag, ".cnt"}, {29'd0, ras_count},     {29'd0, e.cnt});
  endtask

  // Inputs already driven; expect these outputs after the next rising edge
  task automatic step(input string tag, input logic [31:0] pc, input logic vld,
                      input logic rf, input logic uf, input logic [2:0] cnt);
    expect_out(tag, pc, vld, rf, uf, cnt);
    @(posedge clk);
    #1;
    check_out();
    idle();
  endtask

  // Expect these outputs right now (no clock edge)
  task automatic check_now(input string tag, input logic [31:0] pc, input logic vld,
                           input logic rf, input logic uf, input logic [2:0] cnt);
    expect_out(tag, pc, vld, rf, uf, cnt);
    #1;
    check_out();
  endtask

  task automatic idle();
    stall        = 1'b0;
    trap_req     = 1'b0;
    branch_taken = 1'b0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    pc_ready      = 1'b0;
    branch_target = '0;
    ret_addr      = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 32'h1000, 0, 0, 0, 0);

    // Boot and sequential fetch
    rst_n    = 1'b1;
    pc_ready = 1'b1;
    check_now("boot", 32'h1000, 0, 0, 0, 0);
    step("run0", 32'h1000, 1, 0, 0, 0);
    step("run1", 32'h1004, 1, 0, 0, 0);
    step("run2", 32'h1008, 1, 0, 0, 0);

    // Branch captured while stalled, applied when stall drops
    stall = 1; branch_taken = 1; branch_target = wa(32'h1200);
    step("br_stall0", 32'h1008, 0, 0, 0, 0);
    stall = 1;
    step("br_stall1", 32'h1008, 0, 0, 0, 0);
    step("br_apply", 32'h1200, 1, 0, 0, 0);
    step("br_next", 32'h1204, 1, 0, 0, 0);

    // Five pushes into a four-deep stack, then five pops
    pc_ready = 0;
    for (int i = 0; i < 5; i++) begin
      ras_push = 1; ret_addr = wa(32'h1100 + 32'(4 * i));
      step($sformatf("push%0d", i), 32'h1204, 1, 0, 0, (i < 4) ? 3'(i + 1) : 3'd4);
    end
    ras_pop = 1;
    step("pop0", 32'h1110, 1, 0, 0, 3);
    ras_pop = 1;
    step("pop1", 32'h110C, 1, 0, 0, 2);
    ras_pop = 1;
    step("pop2", 32'h1108, 1, 0, 0, 1);
    ras_pop = 1;
    step("pop3", 32'h1104, 1, 0, 0, 0);
    ras_pop = 1; pc_ready = 1;
    step("pop_empty", 32'h1108, 1, 0, 1, 0);
    step("after_uf", 32'h110C, 1, 0, 0, 0);

    // Push and pop together replace the top entry
    pc_ready = 0;
    ras_push = 1; ret_addr = wa(32'h1300);
    step("pp_push0", 32'h110C, 1, 0, 0, 1);
    ras_push = 1; ret_addr = wa(32'h1304);
    step("pp_push1", 32'h110C, 1, 0, 0, 2);
    ras_push = 1; ras_pop = 1; ret_addr = wa(32'h1400);
    step("pp_both", 32'h1304, 1, 0, 0, 2);
    ras_pop = 1;
    step("pp_pop0", 32'h1400, 1, 0, 0, 1);
    ras_pop = 1;
    step("pp_pop1", 32'h1300, 1, 0, 0, 0);

    // Trap beats branch and return, clears the stack, no underflow
    ras_push = 1; ret_addr = wa(32'h1500);
    step("tr_push", 32'h1300, 1, 0, 0, 1);
    trap_req = 1; branch_taken = 1; branch_target = wa(32'h1600); ras_pop = 1;
    step("trap_all", 32'h1F00, 1, 0, 0, 0);

    // Pending return overwritten by branch, underflow while held
    ras_push = 1; ret_addr = wa(32'h1700);
    step("hold_push", 32'h1F00, 1, 0, 0, 1);
    stall = 1; ras_pop = 1;
    step("hold_ret", 32'h1F00, 0, 0, 0, 0);
    stall = 1; branch_taken = 1; branch_target = wa(32'h1800);
    step("hold_br", 32'h1F00, 0, 0, 0, 0);
    stall = 1; ras_pop = 1;
    step("hold_uf", 32'h1F00, 0, 0, 1, 0);
    step("hold_apply", 32'h1800, 1, 0, 0, 0);

    // Pending trap not displaced by a later branch
    stall = 1; trap_req = 1;
    step("hold_trap", 32'h1800, 0, 0, 0, 0);
    stall = 1; branch_taken = 1; branch_target = wa(32'h1900);
    step("hold_trap_br", 32'h1800, 0, 0, 0, 0);
    step("hold_trap_apply", 32'h1F00, 1, 0, 0, 0);

    // Range checks: pc+4 reaching ADDR_MAX, branch below ADDR_MIN, branch to ADDR_MIN
    branch_taken = 1; branch_target = wa(32'h1FFC); ras_push = 1; ret_addr = wa(32'h1A00);
    step("rg_last", 32'h1FFC, 1, 0, 0, 1);
    pc_ready = 1;
    step("rg_wrap", 32'h1F00, 1, 1, 0, 0);
    step("rg_after", 32'h1F04, 1, 0, 0, 0);
    pc_ready = 0;
    branch_taken = 1; branch_target = wa(32'h0800);
    step("rg_low", 32'h1F00, 1, 1, 0, 0);
    branch_taken = 1; branch_target = wa(32'h2000);
    step("rg_max", 32'h1F00, 1, 1, 0, 0);
    branch_taken = 1; branch_target = wa(32'h1000);
    step("rg_min", 32'h1000, 1, 0, 0, 0);

    // Asynchronous reset while a redirect is pending
    pc_ready = 1; ras_push = 1; ret_addr = wa(32'h1B00);
    step("ar_push", 32'h1004, 1, 0, 0, 1);
    pc_ready = 0;
    stall = 1; branch_taken = 1; branch_target = wa(32'h1234);
    step("ar_hold", 32'h1004, 0, 0, 0, 1);
    stall = 1;
    rst_n = 0;
    check_now("ar_reset", 32'h1000, 0, 0, 0, 0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1;
    check_now("ar_boot", 32'h1000, 0, 0, 0, 0);
    step("ar_run", 32'h1000, 1, 0, 0, 0);
    pc_ready = 1;
    step("ar_seq", 32'h1004, 1, 0, 0, 0);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
